// File: rtl/melody_sequencer_pkg.sv
// Shared definitions for the piezo melody sequencer: tone count, note and
// duration codes, ROM entry layout, FSM state encoding and the note decoder.
package melody_sequencer_pkg;

  localparam int NUM_TONES = 13;
  localparam int NOTE_W    = 4;
  localparam int DUR_W     = 3;
  localparam int ENTRY_W   = NOTE_W + DUR_W;

  // Chromatic C4..C5 map onto play_sound bits 0..12; 0, 14 and 15 are silent.
  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_CS4  = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_D4   = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_DS4  = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_E4   = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_F4   = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_FS4  = 4'd7;
  localparam logic [NOTE_W-1:0] NOTE_G4   = 4'd8;
  localparam logic [NOTE_W-1:0] NOTE_GS4  = 4'd9;
  localparam logic [NOTE_W-1:0] NOTE_A4   = 4'd10;
  localparam logic [NOTE_W-1:0] NOTE_AS4  = 4'd11;
  localparam logic [NOTE_W-1:0] NOTE_B4   = 4'd12;
  localparam logic [NOTE_W-1:0] NOTE_C5   = 4'd13;
  localparam logic [NOTE_W-1:0] NOTE_MUTE = 4'd14;

  localparam logic [DUR_W-1:0] DUR_END = 3'd0;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_NOTE  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  function automatic entry_t mk_entry(input logic [NOTE_W-1:0] note,
                                      input logic [DUR_W-1:0] dur);
    entry_t e;
    e.note = note;
    e.dur  = dur;
    return e;
  endfunction

  // Codes outside 1..13 decode to silence.
  function automatic logic [NUM_TONES-1:0] note_to_onehot(input logic [NOTE_W-1:0] note);
    logic [NUM_TONES-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_TONES; i++) begin
      oh[i] = (int'(note) == i + 1);
    end
    return oh;
  endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Control/status bundle between a tune requester and melody_sequencer.
//   start, stop, loop_en : requester -> sequencer
//   play_sound           : one-hot tone enable (all-zero = silence)
//   busy, done, step_idx : sequencer status
interface melody_sequencer_if #(
  parameter int ADDR_W = 5
);
  logic                                        start;
  logic                                        stop;
  logic                                        loop_en;
  logic [melody_sequencer_pkg::NUM_TONES-1:0]  play_sound;
  logic                                        busy;
  logic                                        done;
  logic [ADDR_W-1:0]                           step_idx;

  modport master (
    output start, stop, loop_en,
    input  play_sound, busy, done, step_idx
  );

  modport slave (
    input  start, stop, loop_en,
    output play_sound, busy, done, step_idx
  );
endinterface

// File: rtl/melody_rom.sv
// Combinational tune ROM. addr -> {note, dur} entry.
// SONG_SEL 0 = nap-alarm tune, 1 = short bring-up tune, 2 = two-step tune
// with a muted note and no end marker (exercises wrap-around).
// Addresses past the listed entries read back as end-of-song.
module melody_rom
  import melody_sequencer_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int SONG_SEL = 0
) (
  input  logic [ADDR_W-1:0] addr,
  output entry_t            entry
);

  int unsigned a;

  always_comb begin
    a     = 32'(addr);
    entry = mk_entry(NOTE_REST, DUR_END);
    if (SONG_SEL == 1) begin
      case (a)
        0:       entry = mk_entry(NOTE_C4, 3'd1);
        1:       entry = mk_entry(NOTE_E4, 3'd2);
        2:       entry = mk_entry(NOTE_E4, 3'd1);
        default: entry = mk_entry(NOTE_REST, DUR_END);
      endcase
    end else if (SONG_SEL == 2) begin
      case (a)
        0:       entry = mk_entry(NOTE_MUTE, 3'd1);
        1:       entry = mk_entry(NOTE_C4, 3'd1);
        default: entry = mk_entry(NOTE_REST, DUR_END);
      endcase
    end else begin
      case (a)
        0:       entry = mk_entry(NOTE_C4,   3'd1);
        1:       entry = mk_entry(NOTE_E4,   3'd1);
        2:       entry = mk_entry(NOTE_G4,   3'd1);
        3:       entry = mk_entry(NOTE_C5,   3'd2);
        4:       entry = mk_entry(NOTE_REST, 3'd1);
        5:       entry = mk_entry(NOTE_C5,   3'd1);
        6:       entry = mk_entry(NOTE_G4,   3'd1);
        7:       entry = mk_entry(NOTE_E4,   3'd1);
        8:       entry = mk_entry(NOTE_C4,   3'd2);
        9:       entry = mk_entry(NOTE_REST, 3'd1);
        10:      entry = mk_entry(NOTE_E4,   3'd1);
        11:      entry = mk_entry(NOTE_G4,   3'd1);
        12:      entry = mk_entry(NOTE_A4,   3'd1);
        13:      entry = mk_entry(NOTE_G4,   3'd2);
        14:      entry = mk_entry(NOTE_E4,   3'd1);
        15:      entry = mk_entry(NOTE_C4,   3'd1);
        16:      entry = mk_entry(NOTE_D4,   3'd2);
        17:      entry = mk_entry(NOTE_REST, 3'd1);
        18:      entry = mk_entry(NOTE_C4,   3'd1);
        19:      entry = mk_entry(NOTE_E4,   3'd1);
        20:      entry = mk_entry(NOTE_G4,   3'd1);
        21:      entry = mk_entry(NOTE_C5,   3'd3);
        22:      entry = mk_entry(NOTE_REST, 3'd2);
        default: entry = mk_entry(NOTE_REST, DUR_END);
      endcase
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Plays a ROM melody on the 13-tone piezo block.
//   clk, rst   : clock, synchronous active-high reset
//   bus.slave  : start/stop/loop_en in; play_sound/busy/done/step_idx out
// Each step: one FETCH cycle, dur*TICKS_PER_BEAT-GAP_TICKS cycles of tone,
// GAP_TICKS cycles of silence.
module melody_sequencer
  import melody_sequencer_pkg::*;
#(
  parameter int TICKS_PER_BEAT = 250000,
  parameter int GAP_TICKS      = 10000,
  parameter int SONG_LEN       = 32,
  parameter int ADDR_W         = 5,
  parameter int SONG_SEL       = 0
) (
  input  logic               clk,
  input  logic               rst,
  melody_sequencer_if.slave  bus
);

  localparam int                CNT_W     = $clog2(7 * TICKS_PER_BEAT + 1);
  localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(SONG_LEN - 1);

  state_t                 state_q, state_d;
  logic [NUM_TONES-1:0]   play_sound_q, play_sound_d;
  logic [CNT_W-1:0]       tick_cnt_q, tick_cnt_d;
  logic [ADDR_W-1:0]      step_idx_q, step_idx_d;
  // Set when the last ROM slot has been played; the following FETCH is then
  // an end-of-song regardless of what the ROM holds at step_idx.
  logic                   at_end_q, at_end_d;
  logic                   done_c;
  logic                   is_end;
  entry_t                 rom_entry;

  melody_rom #(
    .ADDR_W   (ADDR_W),
    .SONG_SEL (SONG_SEL)
  ) u_rom (
    .addr  (step_idx_q),
    .entry (rom_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      play_sound_q <= '0;
      tick_cnt_q   <= '0;
      step_idx_q   <= '0;
      at_end_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      play_sound_q <= play_sound_d;
      tick_cnt_q   <= tick_cnt_d;
      step_idx_q   <= step_idx_d;
      at_end_q     <= at_end_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    play_sound_d = play_sound_q;
    tick_cnt_d   = tick_cnt_q;
    step_idx_d   = step_idx_q;
    at_end_d     = at_end_q;
    done_c       = 1'b0;
    is_end       = at_end_q || (rom_entry.dur == DUR_END);

    if (bus.stop) begin
      state_d      = ST_IDLE;
      play_sound_d = '0;
      tick_cnt_d   = '0;
      step_idx_d   = '0;
      at_end_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          play_sound_d = '0;
          step_idx_d   = '0;
          at_end_d     = 1'b0;
          if (bus.start) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (!is_end) begin
            state_d      = ST_NOTE;
            play_sound_d = note_to_onehot(rom_entry.note);
            // Counts down to zero, so load one less than the tone length.
            tick_cnt_d   = CNT_W'(int'(rom_entry.dur) * TICKS_PER_BEAT - GAP_TICKS - 1);
          end else if (bus.loop_en) begin
            step_idx_d = '0;
            at_end_d   = 1'b0;
          end else begin
            done_c     = 1'b1;
            state_d    = ST_IDLE;
            step_idx_d = '0;
            at_end_d   = 1'b0;
          end
        end
        ST_NOTE: begin
          if (tick_cnt_q == '0) begin
            state_d      = ST_GAP;
            play_sound_d = '0;
            tick_cnt_d   = CNT_W'(GAP_TICKS - 1);
          end else begin
            tick_cnt_d = tick_cnt_q - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (tick_cnt_q == '0) begin
            state_d = ST_FETCH;
            if (step_idx_q == LAST_STEP) at_end_d = 1'b1;
            else step_idx_d = step_idx_q + ADDR_W'(1);
          end else begin
            tick_cnt_d = tick_cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.play_sound = play_sound_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_c;
  assign bus.step_idx   = step_idx_q;

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Controller for the 13-tone piezo block. Drives its one-hot playSound[12:0] enable bus from a fixed melody stored in ROM.
- Plays each note for a programmed number of beats, then a short silent gap so repeated notes sound distinct.
- Used as the nap-alarm tune source. Supports start, stop and continuous looping.

Parameters:
- TICKS_PER_BEAT, 250000, clk cycles per beat (250 ms at 1 MHz).
- GAP_TICKS, 10000, silent cycles at the end of every note; must satisfy 0 < GAP_TICKS < TICKS_PER_BEAT.
- SONG_LEN, 32, ROM depth in entries.
- ADDR_W, 5, step index width; 2**ADDR_W >= SONG_LEN.

Ports:
- clk  in  1  system clock (1 MHz nominal).
- rst  in  1  synchronous, active-high reset.
- start  in  1  level sampled each cycle; high in IDLE begins playback.
- stop  in  1  abort playback.
- loop_en  in  1  at end-of-song, restart from step 0 instead of finishing.
- play_sound  out  13  one-hot tone enable to the piezo block; all-zero = silence.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the song ends with loop_en low.
- step_idx  out  ADDR_W  ROM address of the current step.

Behaviour:
- ROM entry: 7 bits = {note[3:0], dur[2:0]}.
  - note 0 = rest; note 1..13 asserts play_sound[note-1]; note 14/15 = rest.
  - dur 1..7 = note length in beats; dur 0 = end-of-song marker.
- ROM read is combinational from step_idx.
- States: IDLE, FETCH, NOTE, GAP.
- IDLE:
  - Outputs play_sound=0, busy=0, step_idx=0.
  - start=1 and stop=0 -> FETCH.
- FETCH (exactly 1 cycle):
  - Registers the entry and loads tick_cnt.
  - dur!=0 -> NOTE.
  - dur==0 and loop_en=1 -> step_idx=0, stay in FETCH.
  - dur==0 and loop_en=0 -> done=1 for this one cycle, then IDLE.
- NOTE:
  - play_sound = decoded note, constant for dur*TICKS_PER_BEAT - GAP_TICKS cycles.
  - Then -> GAP.
- GAP:
  - play_sound=0 for GAP_TICKS cycles.
  - Then step_idx+1 -> FETCH.
- Step period is exactly dur*TICKS_PER_BEAT + 1 cycles.
- Wrap: after step SONG_LEN-1, the sequencer treats the next step as end-of-song (same loop_en rule); step_idx never exceeds SONG_LEN-1.
- Latency: start sampled at edge t -> FETCH at t+1 -> play_sound valid after edge t+2.
- play_sound is registered; never more than one bit set; no glitches.
- stop=1 in any state -> IDLE at the next edge:
  - play_sound=0, busy=0, step_idx=0, done stays 0.
- stop and start high in the same cycle: stop wins.
- start while busy is ignored; there is no restart mid-song.
- loop_en is sampled only in FETCH on an end marker.
- rst=1 -> IDLE, play_sound=0, busy=0, done=0, step_idx=0, tick_cnt=0. This holds regardless of state, including mid-note.
- tick_cnt width: clog2(7*TICKS_PER_BEAT + 1); down-counter, reloaded in FETCH and on NOTE->GAP.

Decomposition:
- Shared package/header piezo_pkg:
  - NUM_TONES=13.
  - Note codes: NOTE_REST=0, NOTE_C4..NOTE_C5 mapping to playSound bits 0..12.
  - DUR_END=0.
  - Entry field widths.
  - State encoding.
- Sub-module melody_rom: SONG_LEN x 7 combinational case ROM holding the alarm tune; address in, entry out.
- The note-to-one-hot decoder stays inline.

Test Plan:
All scenarios use TICKS_PER_BEAT=8, GAP_TICKS=2 and a test ROM of [{1,1},{5,2},{5,1},{0,0}].
- Basic play: start pulse at cycle 10 with loop_en=0.
  - play_sound=13'h0001 on cycles 12-17, 0 on 18-19, FETCH at 20.
  - 13'h0010 on 21-34, 0 on 35-36.
  - 13'h0010 on 38-43, 0 on 44-45.
  - done=1 at cycle 46 only; busy=0 from 47.
- Repeated note: the two note-5 steps are separated by exactly 3 silent cycles (2 gap + 1 fetch); a bench must see a 0 between them.
- Loop: hold loop_en=1 -> after the end marker, step_idx returns to 0, play_sound=13'h0001 resumes 2 cycles later, and done never pulses.
- Stop mid-note: stop=1 on cycle 25 -> play_sound=0, busy=0, step_idx=0 at cycle 26. A later start restarts at step 0.
- Reset mid-note: rst=1 on cycle 30 -> all outputs 0 next edge; start held high during rst is ignored; playback begins only after rst=0.
- Start+stop together in IDLE, and start during busy: no state change / no restart. Also verify note code 14 plays silence and play_sound is one-hot or zero every cycle (assertion).
